// File: rtl/des_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : des_round_sequencer
// Brief    : Control FSM for an iterative DES datapath: load, 16 Feistel
//            rounds with key-schedule rotate control, final swap/FP, and a
//            ready/valid result handshake.
//            Optional feature macro: DES_SEQ_ABORT_EN (abort in ROUND/FINAL).
// Revision : 1.0 - initial release
// ============================================================================
module des_round_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_decrypt,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       abort,
    output logic       busy,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic [3:0] dp_round,
    output logic [1:0] dp_shift,
    output logic       dp_dir,
    output logic       dp_final
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_round   = 2'd1;
    localparam logic [1:0] c_st_final   = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;
    localparam logic [3:0] c_last_round = 4'd15;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_round;
    logic [3:0] w_round_nxt;
    logic       r_mode;
    logic       w_mode_nxt;
    logic       w_abort;

`ifdef DES_SEQ_ABORT_EN
    // Abort only cancels work in flight; IDLE and DONE are unaffected.
    assign w_abort = abort & ((r_state == c_st_round) | (r_state == c_st_final));
`else
    logic w_unused_abort;
    assign w_unused_abort = abort;
    assign w_abort        = 1'b0;
`endif

    // Decrypt runs the key schedule backwards: no rotate before round 0,
    // then right rotates mirroring the encrypt left-rotate amounts.
    function automatic logic [1:0] f_key_shift(input logic dec, input logic [3:0] rnd);
        logic [1:0] sh;
        case (rnd)
            4'd0:                sh = dec ? 2'd0 : 2'd1;
            4'd1, 4'd8, 4'd15:   sh = 2'd1;
            default:             sh = 2'd2;
        endcase
        return sh;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_round <= 4'd0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_mode_nxt  = r_mode;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        dp_load     = 1'b0;
        dp_round_en = 1'b0;
        dp_round    = 4'd0;
        dp_shift    = 2'd0;
        dp_dir      = r_mode;
        dp_final    = 1'b0;

        case (r_state)
            c_st_idle: begin
                in_ready = 1'b1;
                // A request presented during reset must not start the datapath.
                if (in_valid && !rst) begin
                    dp_load     = 1'b1;
                    w_mode_nxt  = in_decrypt;
                    w_round_nxt = 4'd0;
                    w_state_nxt = c_st_round;
                end
            end
            c_st_round: begin
                busy        = 1'b1;
                dp_round_en = 1'b1;
                dp_round    = r_round;
                dp_shift    = f_key_shift(r_mode, r_round);
                if (w_abort) begin
                    w_round_nxt = 4'd0;
                    w_state_nxt = c_st_idle;
                end else if (r_round == c_last_round) begin
                    w_round_nxt = 4'd0;
                    w_state_nxt = c_st_final;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            c_st_final: begin
                busy        = 1'b1;
                dp_final    = 1'b1;
                w_state_nxt = w_abort ? c_st_idle : c_st_done;
            end
            c_st_done: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_round_nxt = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_des_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_round_sequencer
// Brief    : Self-checking bench for des_round_sequencer; per-cycle expected
//            output words queued on stimulus, compared at the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_round_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_decrypt;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       abort;
    logic       busy;
    logic       dp_load;
    logic       dp_round_en;
    logic [3:0] dp_round;
    logic [1:0] dp_shift;
    logic       dp_dir;
    logic       dp_final;

    int n_tests = 0;
    int n_fail  = 0;
    logic       m_mode;
    logic [12:0] sb [$];

    int enc_sched [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_sched [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic decrypt;
        logic toggle;
        logic hold_valid;
        int   bp;
        logic exp_dir;
    } vec_t;
    vec_t vecs [4];

    des_round_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_decrypt  (in_decrypt),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .abort       (abort),
        .busy        (busy),
        .dp_load     (dp_load),
        .dp_round_en (dp_round_en),
        .dp_round    (dp_round),
        .dp_shift    (dp_shift),
        .dp_dir      (dp_dir),
        .dp_final    (dp_final)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] pack_outs();
        return {in_ready, busy, dp_load, dp_round_en, dp_round, dp_shift, dp_dir, dp_final, out_valid};
    endfunction

    function automatic logic [12:0] rec(input logic rdy, input logic bsy, input logic ld,
                                        input logic ren, input logic [3:0] rnd,
                                        input logic [1:0] sh, input logic dir,
                                        input logic fin, input logic ov);
        return {rdy, bsy, ld, ren, rnd, sh, dir, fin, ov};
    endfunction

    function automatic logic [1:0] sched(input logic dir, input int k);
        return dir ? 2'(dec_sched[k]) : 2'(enc_sched[k]);
    endfunction

    function automatic logic [12:0] e_idle(input logic dir, input logic ld);
        return rec(1'b1, 1'b0, ld, 1'b0, 4'd0, 2'd0, dir, 1'b0, 1'b0);
    endfunction

    function automatic logic [12:0] e_round(input int k, input logic dir);
        return rec(1'b0, 1'b1, 1'b0, 1'b1, 4'(k), sched(dir, k), dir, 1'b0, 1'b0);
    endfunction

    function automatic logic [12:0] e_final(input logic dir);
        return rec(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, dir, 1'b1, 1'b0);
    endfunction

    function automatic logic [12:0] e_done(input logic dir);
        return rec(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, dir, 1'b0, 1'b1);
    endfunction

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (rdy,busy,load,ren,round[4],shift[2],dir,final,ovalid)",
                     nm, act, exp);
        end
    endtask

    task automatic expect_now(input string nm);
        logic [12:0] e;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", nm, pack_outs());
        end else begin
            e = sb.pop_front();
            check(nm, pack_outs(), e);
        end
    endtask

    // One clock cycle: drive inputs after the edge, queue expectation, compare.
    task automatic cyc(input logic v, input logic d, input logic r, input logic a,
                       input logic s, input logic [12:0] e, input string nm);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_decrypt = d;
        out_ready  = r;
        abort      = a;
        rst        = s;
        sb.push_back(e);
        expect_now(nm);
    endtask

    task automatic body(input logic v, input logic d, input string nm);
        for (int k = 0; k < 16; k++) cyc(v, d, 1'b0, 1'b0, 1'b0, e_round(k, d), nm);
        cyc(v, d, 1'b0, 1'b0, 1'b0, e_final(d), {nm, "_final"});
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int last;
        last = 19 + v.bp;
        sb.push_back(e_idle(m_mode, 1'b1));
        for (int k = 0; k < 16; k++) sb.push_back(e_round(k, v.exp_dir));
        sb.push_back(e_final(v.exp_dir));
        for (int k = 0; k <= v.bp; k++) sb.push_back(e_done(v.exp_dir));
        sb.push_back(e_idle(v.exp_dir, 1'b0));
        m_mode = v.exp_dir;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            rst   = 1'b0;
            abort = 1'b0;
            if (c == 0) begin
                in_valid   = 1'b1;
                in_decrypt = v.decrypt;
            end else begin
                in_valid = (c < last) ? v.hold_valid : 1'b0;
                if (v.toggle) in_decrypt = ~in_decrypt;
            end
            if (c >= 18 && c < last) out_ready = (c == last - 1);
            else                     out_ready = (v.bp == 0) && (c < last);
            expect_now($sformatf("vec%0d_c%0d", idx, c));
        end
    endtask

    initial begin
        vecs[0] = '{decrypt: 1'b0, toggle: 1'b0, hold_valid: 1'b0, bp: 0, exp_dir: 1'b0};
        vecs[1] = '{decrypt: 1'b1, toggle: 1'b1, hold_valid: 1'b0, bp: 0, exp_dir: 1'b1};
        vecs[2] = '{decrypt: 1'b0, toggle: 1'b1, hold_valid: 1'b1, bp: 5, exp_dir: 1'b0};
        vecs[3] = '{decrypt: 1'b1, toggle: 1'b0, hold_valid: 1'b1, bp: 2, exp_dir: 1'b1};

        rst = 1'b1; in_valid = 1'b1; in_decrypt = 1'b1; out_ready = 1'b0; abort = 1'b0;
        m_mode = 1'b0;

        // Reset with a request pending: no load, reset output values.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, e_idle(1'b0, 1'b0), "reset_hold");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_idle(1'b0, 1'b0), "reset_release");

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Backpressure with in_valid held, then re-accept in the first IDLE cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(m_mode, 1'b1), "bp_accept");
        m_mode = 1'b0;
        body(1'b1, 1'b0, "bp_round");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_done(1'b0), "bp_hold");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e_done(1'b0), "bp_release");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e_idle(1'b0, 1'b1), "bp_reaccept");
        m_mode = 1'b1;

        // Reset asserted during round 7 of that decrypt operation.
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_round(k, 1'b1), "rr_round");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, e_round(7, 1'b1), "rr_round7");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(1'b0, 1'b0), "rr_after");
        m_mode = 1'b0;
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(1'b0, 1'b0), "rr_quiet");
        run_vec(vecs[0], 10);

        // Reset while DONE is waiting on out_ready.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e_idle(m_mode, 1'b1), "rd_accept");
        m_mode = 1'b1;
        body(1'b0, 1'b1, "rd_round");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_done(1'b1), "rd_done");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, e_done(1'b1), "rd_rst");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_idle(1'b0, 1'b0), "rd_after");
        m_mode = 1'b0;

        // Abort at round 3.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(m_mode, 1'b1), "ab_accept");
        m_mode = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_round(k, 1'b0), "ab_round");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_round(3, 1'b0), "ab_round3");
`ifdef DES_SEQ_ABORT_EN
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(1'b0, 1'b0), "ab_idle");
`else
        for (int k = 4; k < 16; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_round(k, 1'b0), "ab_cont");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_final(1'b0), "ab_final");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e_done(1'b0), "ab_done");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(1'b0, 1'b0), "ab_idle");
`endif

        // Abort in IDLE (at accept) and in DONE has no effect.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, e_idle(m_mode, 1'b1), "abi_accept");
        m_mode = 1'b1;
        body(1'b0, 1'b1, "abd_round");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, e_done(1'b1), "abd_done");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e_done(1'b1), "abd_release");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_idle(1'b1, 1'b0), "abd_idle");

        // Abort and reset together: reset outcome, mode cleared.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e_idle(m_mode, 1'b1), "abr_accept");
        m_mode = 1'b1;
        for (int k = 0; k < 2; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_round(k, 1'b1), "abr_round");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, e_round(2, 1'b1), "abr_both");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(1'b0, 1'b0), "abr_after");
        m_mode = 1'b0;
        run_vec(vecs[1], 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
